// File: rtl/regfile_param_2r1w.sv
// rtl/regfile_param_2r1w.sv - parametrised 2-read/1-write register file with registered, bypassed reads
// Optional REGFILE_ZERO_REG_EN: register DEPTH-1 is hardwired to zero.
module regfile_param_2r1w #(
  parameter int WIDTH     = 64,
  parameter int ADDR_BITS = 5
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       D,
  input  logic [ADDR_BITS-1:0]   DA,
  input  logic                   W,
  input  logic [ADDR_BITS-1:0]   SA,
  input  logic [ADDR_BITS-1:0]   SB,
  input  logic                   RE,
  output logic [WIDTH-1:0]       A,
  output logic [WIDTH-1:0]       B,
  output logic [2**ADDR_BITS-1:0] WRITTEN
);

  localparam int DEPTH = 2**ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] TOP_ADDR = ADDR_BITS'(DEPTH - 1);

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_TOP = 1'b1;
`else
  localparam bit ZERO_TOP = 1'b0;
`endif

  logic [WIDTH-1:0] r [DEPTH];
  logic             wr_en;
  logic [WIDTH-1:0] next_a;
  logic [WIDTH-1:0] next_b;

  // Writes to the hardwired-zero register are dropped, which also suppresses its bypass.
  assign wr_en = W && !(ZERO_TOP && (DA == TOP_ADDR));

  always_comb begin
    next_a = r[SA];
    next_b = r[SB];
    if (wr_en && (DA == SA)) next_a = D;
    if (wr_en && (DA == SB)) next_b = D;
    if (ZERO_TOP && (SA == TOP_ADDR)) next_a = '0;
    if (ZERO_TOP && (SB == TOP_ADDR)) next_b = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r[i] <= '0;
      WRITTEN <= '0;
      A       <= '0;
      B       <= '0;
    end else begin
      if (wr_en) begin
        r[DA]       <= D;
        WRITTEN[DA] <= 1'b1;
      end
      if (RE) begin
        A <= next_a;
        B <= next_b;
      end
    end
  end

endmodule

// File: tb/tb_regfile_param_2r1w.sv
// tb/tb_regfile_param_2r1w.sv - self-checking bench for regfile_param_2r1w against an array model
module tb_regfile_param_2r1w;

  localparam int WIDTH = 64;
  localparam int AB    = 5;
  localparam int DEPTH = 32;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO = 1'b1;
`else
  localparam bit ZERO = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] D;
  logic [AB-1:0]    DA, SA, SB;
  logic             W, RE;
  logic [WIDTH-1:0] A, B;
  logic [DEPTH-1:0] WRITTEN;

  regfile_param_2r1w #(.WIDTH(WIDTH), .ADDR_BITS(AB)) dut (
    .clock(clock), .reset(reset), .D(D), .DA(DA), .W(W),
    .SA(SA), .SB(SB), .RE(RE), .A(A), .B(B), .WRITTEN(WRITTEN)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  logic [WIDTH-1:0] m [DEPTH];
  logic [DEPTH-1:0] mw;
  logic [WIDTH-1:0] exp_a, exp_b;

  function automatic logic [WIDTH-1:0] model_read(input int sel, input logic w, input int da,
                                                  input logic [WIDTH-1:0] d);
    if (ZERO && sel == DEPTH - 1) return '0;
    if (w && da == sel) return d;
    return m[sel];
  endfunction

  // Applies one cycle of stimulus, advances the model, and returns #1 after the edge.
  task automatic drive(input logic rst, input logic w, input int da, input logic [WIDTH-1:0] d,
                       input logic re, input int sa, input int sb);
    reset = rst; W = w; DA = AB'(da); D = d; RE = re; SA = AB'(sa); SB = AB'(sb);
    if (rst) begin
      exp_a = '0; exp_b = '0; mw = '0;
      for (int i = 0; i < DEPTH; i++) m[i] = '0;
    end else begin
      if (re) begin
        exp_a = model_read(sa, w, da, d);
        exp_b = model_read(sb, w, da, d);
      end
      if (w && !(ZERO && da == DEPTH - 1)) begin
        m[da]  = d;
        mw[da] = 1'b1;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    drive(1'b1, 1'b0, 0, '0, 1'b0, 0, 0);
    drive(1'b0, 1'b0, 0, '0, 1'b1, 0, 31);
    tests++; if (A !== 64'h0) begin fails++; $display("FAIL reset_a: got %h want 0", A); end
    tests++; if (B !== 64'h0) begin fails++; $display("FAIL reset_b: got %h want 0", B); end
    tests++; if (WRITTEN !== 32'h0) begin fails++; $display("FAIL reset_written: got %h want 0", WRITTEN); end
  endtask

  task automatic test_write_sweep;
    logic [DEPTH-1:0] want;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b1, i, {$urandom, $urandom}, 1'b1, (i + DEPTH - 1) % DEPTH, (i + DEPTH - 2) % DEPTH);
      tests++; if (A !== exp_a) begin fails++; $display("FAIL sweep_a[%0d]: got %h want %h", i, A, exp_a); end
      tests++; if (B !== exp_b) begin fails++; $display("FAIL sweep_b[%0d]: got %h want %h", i, B, exp_b); end
    end
    want = ZERO ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
    tests++; if (WRITTEN !== want) begin fails++; $display("FAIL sweep_written: got %h want %h", WRITTEN, want); end
  endtask

  task automatic test_bypass;
    drive(1'b0, 1'b1, 5, 64'h1111, 1'b0, 0, 0);
    drive(1'b0, 1'b1, 5, 64'hABCD, 1'b1, 5, 5);
    tests++; if (A !== 64'hABCD) begin fails++; $display("FAIL bypass_a: got %h want abcd", A); end
    tests++; if (B !== 64'hABCD) begin fails++; $display("FAIL bypass_b: got %h want abcd", B); end
  endtask

  task automatic test_hold;
    logic [WIDTH-1:0] cap;
    drive(1'b0, 1'b0, 0, '0, 1'b1, 3, 4);
    cap = m[3];
    tests++; if (A !== cap) begin fails++; $display("FAIL hold_capture: got %h want %h", A, cap); end
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 3, 64'h55, 1'b0, 9, 10);
      tests++; if (A !== cap) begin fails++; $display("FAIL hold_a[%0d]: got %h want %h", k, A, cap); end
    end
    drive(1'b0, 1'b0, 0, '0, 1'b1, 3, 3);
    tests++; if (A !== 64'h55) begin fails++; $display("FAIL hold_reread: got %h want 55", A); end
  endtask

  task automatic test_reset_mid;
    drive(1'b0, 1'b1, 7, 64'h1234, 1'b0, 0, 0);
    drive(1'b0, 1'b0, 0, '0, 1'b1, 7, 7);
    drive(1'b1, 1'b1, 7, 64'hFF, 1'b1, 7, 7);
    tests++; if (A !== 64'h0 || B !== 64'h0) begin fails++; $display("FAIL rstmid_ab: got %h/%h want 0/0", A, B); end
    tests++; if (WRITTEN !== 32'h0) begin fails++; $display("FAIL rstmid_written: got %h want 0", WRITTEN); end
    drive(1'b0, 1'b0, 0, '0, 1'b1, 7, 7);
    tests++; if (A !== 64'h0) begin fails++; $display("FAIL rstmid_r7: got %h want 0", A); end
  endtask

  task automatic test_top_reg;
    logic [WIDTH-1:0] want;
    want = ZERO ? 64'h0 : 64'hDEAD;
    drive(1'b0, 1'b1, 31, 64'hDEAD, 1'b1, 31, 31);
    tests++; if (A !== want) begin fails++; $display("FAIL top_bypass: got %h want %h", A, want); end
    tests++; if (WRITTEN[31] !== !ZERO) begin fails++; $display("FAIL top_written: got %b want %b", WRITTEN[31], !ZERO); end
    drive(1'b0, 1'b0, 0, '0, 1'b1, 31, 0);
    tests++; if (A !== want) begin fails++; $display("FAIL top_reread: got %h want %h", A, want); end
  endtask

  task automatic test_random;
    for (int n = 0; n < 300; n++) begin
      drive(($urandom_range(0, 39) == 0), $urandom_range(0, 1), $urandom_range(0, DEPTH - 1),
            {$urandom, $urandom}, $urandom_range(0, 3) != 0,
            $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1));
      tests++;
      if (A !== exp_a || B !== exp_b || WRITTEN !== mw) begin
        fails++;
        $display("FAIL random[%0d]: got A=%h B=%h WR=%h want A=%h B=%h WR=%h", n, A, B, WRITTEN, exp_a, exp_b, mw);
      end
    end
  endtask

  initial begin
    reset = 1'b1; W = 1'b0; RE = 1'b0; D = '0; DA = '0; SA = '0; SB = '0;
    test_reset();
    test_write_sweep();
    test_bypass();
    test_hold();
    test_reset_mid();
    test_top_reg();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
